// File: rtl/dma_bus_arbiter.sv
// Shares the single memory port between the 6502C CPU and two DMA read requesters.
// The CPU is held off with RDY, which only takes effect on a CPU read cycle.
module dma_bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    input  logic [1:0]  dma_req,
    input  logic [15:0] dma_addr0,
    input  logic [15:0] dma_addr1,
    output logic [1:0]  dma_grant,
    output logic [7:0]  dma_data,
    output logic [1:0]  dma_valid,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we_L,
    output logic        mem_re_L,
    input  logic [7:0]  mem_rdata
);

    localparam logic [1:0] ST_CPU     = 2'd0;
    localparam logic [1:0] ST_HALT    = 2'd1;
    localparam logic [1:0] ST_DMA     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       rr;
    logic       cpu_rdy_r;
    logic       any_req;
    logic       gsel;
    logic       serving;
    logic [7:0] data_p1;
    logic [1:0] vld_p1;

    assign any_req = |dma_req;

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        gsel = rr;
        if (dma_req == 2'b01)
            gsel = 1'b0;
        else if (dma_req == 2'b10)
            gsel = 1'b1;
    end

    assign serving   = (state == ST_DMA) && any_req;
    assign dma_grant = serving ? (gsel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        if (state == ST_DMA) begin
            mem_addr  = gsel ? dma_addr1 : dma_addr0;
            mem_wdata = cpu_wdata;
            mem_we_L  = 1'b1;
            mem_re_L  = 1'b0;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we_L  = cpu_rw;
            mem_re_L  = ~cpu_rw;
        end
    end

    assign cpu_rdata = mem_rdata;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_CPU: begin
                if (any_req)
                    state_nx = ST_HALT;
            end
            ST_HALT: begin
                // CPU writes cannot be stalled, so wait here until a read shows up.
                if (!any_req)
                    state_nx = ST_CPU;
                else if (cpu_rw)
                    state_nx = ST_DMA;
            end
            ST_DMA: begin
                if (!any_req) begin
                    state_nx = ST_CPU;
                    cnt_nx   = 4'd0;
                end else if (cnt + 4'd1 == BURST_LIM) begin
                    state_nx = ST_RELEASE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx   = cnt + 4'd1;
                end
            end
            default: begin
                state_nx = any_req ? ST_HALT : ST_CPU;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_CPU;
            cnt       <= 4'd0;
            rr        <= 1'b0;
            cpu_rdy_r <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cpu_rdy_r <= (state_nx == ST_CPU) || (state_nx == ST_RELEASE);
            if (serving)
                rr <= ~gsel;
        end
    end

    // Stage p1: read data captured at the end of the grant cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_p1 <= 8'h00;
            vld_p1  <= 2'b00;
        end else begin
            vld_p1 <= dma_grant;
            if (serving)
                data_p1 <= mem_rdata;
        end
    end

    assign cpu_rdy   = cpu_rdy_r;
    assign dma_data  = data_p1;
    assign dma_valid = vld_p1;

endmodule
